mmio_uart_tx: RTL and testbench
===============================

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter TX_ADDR, default 32'h0000_0100, byte address of the transmit data register.
REQ-002 Parameter CLKS_PER_BIT, default 4, clock cycles per serial bit; legal range 2..65535.
REQ-003 Parameter FIFO_DEPTH, default 4, transmit FIFO entries; power of two, 2..16.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk; 0 = reset.
REQ-006 write_enable  input  1  processor store strobe, same signal that drives data memory.
REQ-007 address_to_mem  input  32  processor store byte address.
REQ-008 data_to_mem  input  32  processor store data; bits [7:0] are the transmitted byte.
REQ-009 tx  output  1  serial line, 8N1, idle high, LSB first.
REQ-010 busy  output  1  high while a frame is being shifted out (state not IDLE).
REQ-011 fifo_count  output  $clog2(FIFO_DEPTH)+1  number of queued bytes not yet started.
REQ-012 overflow  output  1  sticky flag, set when a store is dropped because FIFO is full.

Function
REQ-013 Push condition: write_enable=1 and address_to_mem==TX_ADDR (full 32-bit compare); all other stores ignored, with no effect on state.
REQ-014 Accepted push writes data_to_mem[7:0] into FIFO at the rising edge; fifo_count increments at that edge.
REQ-015 Push when fifo_count==FIFO_DEPTH and no pop in the same cycle: byte dropped, overflow set to 1 at that edge, FIFO unchanged.
REQ-016 Push and pop in the same cycle: both take effect; fifo_count unchanged; push accepted even when full.
REQ-017 FIFO pointers wrap modulo FIFO_DEPTH; bytes leave in push order.
REQ-018 FSM states IDLE, START, DATA, STOP; bit timer counts 0..CLKS_PER_BIT-1; bit index counts 0..7 in DATA.
REQ-019 IDLE: tx=1; if fifo_count>0, pop head into shift register and enter START at the same edge; else stay.
REQ-020 START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
REQ-021 DATA: tx=shift[bit index] for CLKS_PER_BIT cycles per bit, bits 0..7; after bit 7 enter STOP.
REQ-022 STOP: tx=1 for CLKS_PER_BIT cycles; on last STOP cycle, if fifo_count>0, pop and enter START directly (no idle gap); else IDLE.
REQ-023 Frame length exactly 10*CLKS_PER_BIT cycles; tx, busy, fifo_count, overflow are registered outputs.
REQ-024 tx first goes low on the edge after the one that pushed into an empty FIFO while IDLE.
REQ-025 Write data bits [31:8] and address byte offsets other than exact TX_ADDR are not interpreted.

Reset
REQ-026 reset=0 at a rising edge: FSM to IDLE, tx=1, busy=0, fifo_count=0, pointers=0, overflow=0, timers=0.
REQ-027 Reset mid-frame aborts the frame: tx=1 from the next edge, queued bytes discarded.
REQ-028 Push coinciding with reset=0 is discarded.
REQ-029 overflow clears only by reset.

Verification
REQ-030 CLKS_PER_BIT=4; single store 0x0000_0055 to 0x100 -> tx low 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, high 4 cycles; busy high 40 cycles; fifo_count 1 for one cycle then 0.
REQ-031 Store 0xA5 to 0x104 and to 0x000 -> tx stays 1, fifo_count 0, busy 0.
REQ-032 Six stores to 0x100 on consecutive cycles, bytes 0x01..0x06 (depth 4) -> 0x01 popped on second edge, 0x02..0x05 queued, fifo_count=4, 0x06 dropped, overflow=1; serial output 0x01..0x05 back-to-back, no idle gap, total 200 cycles.
REQ-033 Store at the exact cycle FIFO is full and STOP last cycle pops -> byte accepted, overflow stays 0, fifo_count stays 4.
REQ-034 reset=0 for one cycle at cycle 17 of frame 0x3C with two bytes queued -> tx=1, busy=0, fifo_count=0 next edge; no further frames.
REQ-035 CLKS_PER_BIT=2, store 0xFF -> tx low 2 cycles, high 18 cycles; busy high exactly 20 cycles.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: stores to TX_ADDR are queued in a small FIFO
// and shifted out as 8N1 frames, LSB first, idle-high line.
module mmio_uart_tx #(
  parameter logic [31:0] TX_ADDR      = 32'h0000_0100,
  parameter int          CLKS_PER_BIT = 4,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          write_enable,
  input  logic [31:0]                   address_to_mem,
  input  logic [31:0]                   data_to_mem,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int              PW        = $clog2(FIFO_DEPTH);
  localparam int              CW        = PW + 1;
  localparam logic [15:0]     LAST_TICK = 16'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   FULL      = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        r_state, w_state_nx;
  logic [15:0]   r_timer, w_timer_nx;
  logic [2:0]    r_bit_idx, w_bit_nx;
  logic [7:0]    r_shift, w_shift_nx;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_tx, r_busy, r_overflow;
  logic          w_tx_nx, w_pop, w_push, w_push_req, w_nonempty, w_last_tick;
  logic          w_unused;

  // Only the low data byte is transmitted; the upper bits are deliberately ignored.
  assign w_unused    = &{1'b0, data_to_mem[31:8]};

  assign w_push_req  = write_enable && (address_to_mem == TX_ADDR);
  assign w_nonempty  = (r_count != '0);
  assign w_last_tick = (r_timer == LAST_TICK);
  // A full FIFO still accepts a store when the head leaves in the same cycle.
  assign w_push      = w_push_req && ((r_count != FULL) || w_pop);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nx = r_state;
    w_timer_nx = r_timer;
    w_bit_nx   = r_bit_idx;
    w_shift_nx = r_shift;
    w_pop      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_nonempty) begin
          w_pop      = 1'b1;
          w_shift_nx = r_mem[r_rd_ptr];
          w_timer_nx = '0;
          w_state_nx = S_START;
        end
      end
      S_START: begin
        if (w_last_tick) begin
          w_timer_nx = '0;
          w_bit_nx   = '0;
          w_state_nx = S_DATA;
        end else begin
          w_timer_nx = r_timer + 16'd1;
        end
      end
      S_DATA: begin
        if (w_last_tick) begin
          w_timer_nx = '0;
          if (r_bit_idx == 3'd7) w_state_nx = S_STOP;
          else                   w_bit_nx   = r_bit_idx + 3'd1;
        end else begin
          w_timer_nx = r_timer + 16'd1;
        end
      end
      S_STOP: begin
        if (w_last_tick) begin
          w_timer_nx = '0;
          // Chain straight into the next frame so queued bytes leave without an idle gap.
          if (w_nonempty) begin
            w_pop      = 1'b1;
            w_shift_nx = r_mem[r_rd_ptr];
            w_state_nx = S_START;
          end else begin
            w_state_nx = S_IDLE;
          end
        end else begin
          w_timer_nx = r_timer + 16'd1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase

    case (w_state_nx)
      S_START: w_tx_nx = 1'b0;
      S_DATA:  w_tx_nx = w_shift_nx[w_bit_nx];
      default: w_tx_nx = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_timer   <= w_timer_nx;
      r_bit_idx <= w_bit_nx;
      r_shift   <= w_shift_nx;
      r_tx      <= w_tx_nx;
      r_busy    <= (w_state_nx != S_IDLE);
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push_req && !w_push) r_overflow <= 1'b1;
    end
  end

  // NOTE: FIFO storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (reset && w_push) r_mem[r_wr_ptr] <= data_to_mem[7:0];
  end

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: directed scenarios plus randomized stores,
// compared cycle by cycle against a frame-timeline reference model.
module tb_mmio_uart_tx;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;
  localparam logic [31:0] ADDR  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset, we;
  logic [31:0] addr, data;
  logic        tx, busy, overflow;
  logic [2:0]  fifo_count;

  logic        reset2, we2;
  logic [31:0] addr2, data2;
  logic        tx2, busy2, overflow2;
  logic [2:0]  fifo_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmio_uart_tx #(.TX_ADDR(ADDR), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .write_enable(we), .address_to_mem(addr),
    .data_to_mem(data), .tx(tx), .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
  );

  mmio_uart_tx #(.TX_ADDR(ADDR), .CLKS_PER_BIT(2), .FIFO_DEPTH(DEPTH)) dut2 (
    .clk(clk), .reset(reset2), .write_enable(we2), .address_to_mem(addr2),
    .data_to_mem(data2), .tx(tx2), .busy(busy2), .fifo_count(fifo_count2), .overflow(overflow2)
  );

  // Reference model: pending bytes, the byte on the wire, and how far into its frame we are.
  logic [7:0] m_q[$];
  logic [7:0] m_cur = 8'h00;
  int         m_elapsed = -1;   // -1 means line idle
  logic       m_ovf = 1'b0;

  function automatic logic m_tx();
    int slot;
    if (m_elapsed < 0) return 1'b1;
    slot = m_elapsed / CPB;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return m_cur[slot-1];
  endfunction

  function automatic logic [5:0] m_out();
    return {m_tx(), (m_elapsed >= 0), 3'(m_q.size()), m_ovf};
  endfunction

  task automatic tick(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic pop, req;
    reset = r; we = w; addr = a; data = d;
    @(posedge clk);
    if (!r) begin
      m_q.delete();
      m_elapsed = -1;
      m_ovf     = 1'b0;
    end else begin
      pop = (m_q.size() > 0) && (m_elapsed < 0 || m_elapsed == FRAME - 1);
      req = w && (a == ADDR);
      if (req && m_q.size() == DEPTH && !pop) begin
        m_ovf = 1'b1;
        req   = 1'b0;
      end
      if (pop) begin
        m_cur     = m_q.pop_front();
        m_elapsed = 0;
      end else if (m_elapsed >= 0) begin
        m_elapsed = (m_elapsed == FRAME - 1) ? -1 : m_elapsed + 1;
      end
      if (req) m_q.push_back(d[7:0]);
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b0, 32'h0, 32'h0);
    tick(1'b0, 1'b1, ADDR, 32'h11);   // store during reset must vanish
    checks++;
    if ({tx, busy, fifo_count, overflow} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got %b want %b", {tx, busy, fifo_count, overflow}, 6'b100000);
    end
    tick(1'b1, 1'b0, 32'h0, 32'h0);
    checks++;
    if ({tx, busy, fifo_count} !== {1'b1, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset_push_dropped got %b want %b", {tx, busy, fifo_count}, 5'b10000);
    end
  endtask

  task automatic test_single();
    int busy_cycles = 0;
    tick(1'b1, 1'b1, ADDR, 32'h0000_0055);
    checks++;
    if ({tx, busy, fifo_count} !== {1'b1, 1'b0, 3'd1}) begin
      errors++;
      $display("FAIL single_queued got %b want %b", {tx, busy, fifo_count}, 5'b10001);
    end
    for (int i = 0; i < FRAME + 6; i++) begin
      tick(1'b1, 1'b0, 32'h0, 32'h0);
      busy_cycles += busy;
      checks++;
      if ({tx, busy, fifo_count, overflow} !== m_out()) begin
        errors++;
        $display("FAIL single_frame cycle %0d got %b want %b", i, {tx, busy, fifo_count, overflow}, m_out());
      end
    end
    checks++;
    if (busy_cycles != FRAME) begin
      errors++;
      $display("FAIL single_busy_len got %0d want %0d", busy_cycles, FRAME);
    end
  endtask

  task automatic test_ignored();
    logic [31:0] addrs [3];
    addrs[0] = 32'h0000_0104;
    addrs[1] = 32'h0000_0000;
    addrs[2] = 32'h8000_0100;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, addrs[i], 32'h0000_00A5);
      tick(1'b1, 1'b0, 32'h0, 32'h0);
      checks++;
      if ({tx, busy, fifo_count} !== {1'b1, 1'b0, 3'd0}) begin
        errors++;
        $display("FAIL ignored_store addr %h got %b want %b", addrs[i], {tx, busy, fifo_count}, 5'b10000);
      end
    end
    tick(1'b1, 1'b0, ADDR, 32'h0000_00A5);   // address match but no strobe
    checks++;
    if ({tx, busy, fifo_count} !== {1'b1, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL ignored_no_strobe got %b want %b", {tx, busy, fifo_count}, 5'b10000);
    end
  endtask

  task automatic test_overflow();
    int busy_cycles = 0;
    tick(1'b0, 1'b0, 32'h0, 32'h0);
    for (int b = 1; b <= 6; b++) begin
      tick(1'b1, 1'b1, ADDR, 32'(b));
      busy_cycles += busy;
    end
    checks++;
    if ({fifo_count, overflow, busy} !== {3'd4, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL overflow_fill got %b want %b", {fifo_count, overflow, busy}, 5'b10011);
    end
    for (int i = 0; i < 5 * FRAME + 10; i++) begin
      tick(1'b1, 1'b0, 32'h0, 32'h0);
      busy_cycles += busy;
      checks++;
      if ({tx, busy, fifo_count, overflow} !== m_out()) begin
        errors++;
        $display("FAIL overflow_stream cycle %0d got %b want %b", i, {tx, busy, fifo_count, overflow}, m_out());
      end
    end
    checks++;
    if (busy_cycles != 5 * FRAME) begin
      errors++;
      $display("FAIL overflow_busy_len got %0d want %0d", busy_cycles, 5 * FRAME);
    end
  endtask

  task automatic test_full_pop();
    int guard = 0;
    tick(1'b0, 1'b0, 32'h0, 32'h0);
    for (int b = 1; b <= 5; b++) tick(1'b1, 1'b1, ADDR, 32'(8'h20 + b));
    while (!(m_elapsed == FRAME - 1 && m_q.size() == DEPTH) && guard < 3 * FRAME) begin
      tick(1'b1, 1'b0, 32'h0, 32'h0);
      guard++;
    end
    checks++;
    if (guard >= 3 * FRAME) begin
      errors++;
      $display("FAIL full_pop_setup got guard %0d want < %0d", guard, 3 * FRAME);
    end
    tick(1'b1, 1'b1, ADDR, 32'h0000_0077);
    checks++;
    if ({fifo_count, overflow} !== {3'd4, 1'b0}) begin
      errors++;
      $display("FAIL full_pop_accept got %b want %b", {fifo_count, overflow}, 4'b1000);
    end
    for (int i = 0; i < 4 * FRAME + 4; i++) begin
      tick(1'b1, 1'b0, 32'h0, 32'h0);
      checks++;
      if ({tx, busy, fifo_count, overflow} !== m_out()) begin
        errors++;
        $display("FAIL full_pop_drain cycle %0d got %b want %b", i, {tx, busy, fifo_count, overflow}, m_out());
      end
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b0, 1'b0, 32'h0, 32'h0);
    tick(1'b1, 1'b1, ADDR, 32'h0000_003C);
    tick(1'b1, 1'b1, ADDR, 32'h0000_0011);
    tick(1'b1, 1'b1, ADDR, 32'h0000_0022);
    while (m_elapsed != 17) tick(1'b1, 1'b0, 32'h0, 32'h0);
    checks++;
    if ({busy, fifo_count} !== {1'b1, 3'd2}) begin
      errors++;
      $display("FAIL reset_mid_before got %b want %b", {busy, fifo_count}, 4'b1010);
    end
    tick(1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if ({tx, busy, fifo_count} !== {1'b1, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset_mid_abort got %b want %b", {tx, busy, fifo_count}, 5'b10000);
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick(1'b1, 1'b0, 32'h0, 32'h0);
      checks++;
      if ({tx, busy, fifo_count} !== {1'b1, 1'b0, 3'd0}) begin
        errors++;
        $display("FAIL reset_mid_quiet cycle %0d got %b want %b", i, {tx, busy, fifo_count}, 5'b10000);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    tick(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    a = ADDR;
        2:       a = ADDR + 32'd4;
        default: a = $urandom;
      endcase
      tick(($urandom_range(0, 399) != 0), ($urandom_range(0, 3) == 0), a, $urandom);
      checks++;
      if ({tx, busy, fifo_count, overflow} !== m_out()) begin
        errors++;
        $display("FAIL random cycle %0d got %b want %b", i, {tx, busy, fifo_count, overflow}, m_out());
      end
    end
  endtask

  task automatic test_cpb2();
    int low = 0, high_busy = 0, busy_cnt = 0;
    reset2 = 1'b1; we2 = 1'b1; addr2 = ADDR; data2 = 32'h0000_00FF;
    @(posedge clk); #1;
    we2 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        checks++;
        if (tx2 !== 1'b0) begin
          errors++;
          $display("FAIL cpb2_start_edge got %b want 0", tx2);
        end
      end
      low       += (tx2 == 1'b0);
      high_busy += (tx2 == 1'b1 && busy2 == 1'b1);
      busy_cnt  += busy2;
    end
    checks++;
    if (low != 2 || high_busy != 18 || busy_cnt != 20) begin
      errors++;
      $display("FAIL cpb2_frame got low=%0d high=%0d busy=%0d want low=2 high=18 busy=20",
               low, high_busy, busy_cnt);
    end
  endtask

  initial begin
    reset = 1'b0; we = 1'b0; addr = '0; data = '0;
    reset2 = 1'b0; we2 = 1'b0; addr2 = '0; data2 = '0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_ignored();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_random();
    test_cpb2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
